// File: rtl/ram_if_pkg.sv
// Shared types and default widths for the single-port RAM controller,
// its RAM model and benches.
package ram_if_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_LEN_WIDTH  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_TURN  = 3'd4
  } ram_state_t;

endpackage

// File: rtl/ram_bus_driver.sv
// Tristate driver for the shared RAM data bus plus the read-capture register
// that turns each addressed read beat into a one-cycle rd_valid pulse.
module ram_bus_driver #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  drive,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  capture,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  assign mem_data = drive ? wr_data : {DATA_WIDTH{1'bz}};

  // Reset clears rd_valid so a read in flight is discarded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= {DATA_WIDTH{1'b0}};
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= capture;
      if (capture) begin
        rd_data <= mem_data;
      end else begin
        rd_data <= rd_data;
      end
    end
  end

endmodule

// File: rtl/ram_sp_master.sv
// Burst request front end to single-port RAM strobe interface: per-beat
// cycles with auto-incrementing address and a TURN cycle for bus turnaround.
module ram_sp_master
  import ram_if_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  ram_state_t            state;
  ram_state_t            next_state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  beats_q;
  logic                  accept;
  logic                  issue;
  logic                  last_beat;

  assign last_beat   = (beats_q == {LEN_WIDTH{1'b0}});
  assign mem_address = addr_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Burst address and remaining-beat counter; address wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= {ADDR_WIDTH{1'b0}};
      beats_q <= {LEN_WIDTH{1'b0}};
    end else if (accept) begin
      addr_q  <= req_addr;
      beats_q <= req_len;
    end else if (issue) begin
      addr_q  <= addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      beats_q <= beats_q - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      addr_q  <= addr_q;
      beats_q <= beats_q;
    end
  end

  // Next-state and strobe decode; write beats stall on wr_valid
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    wr_ready   = 1'b0;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_oe     = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    issue      = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          next_state = req_write ? ST_WRITE : ST_READ;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          issue      = 1'b1;
          mem_cs     = 1'b1;
          mem_we     = 1'b1;
          next_state = last_beat ? ST_TURN : ST_WRITE;
        end else begin
          next_state = ST_WRITE;
        end
      end
      ST_READ: begin
        issue      = 1'b1;
        mem_cs     = 1'b1;
        mem_oe     = 1'b1;
        next_state = last_beat ? ST_DRAIN : ST_READ;
      end
      ST_DRAIN: begin
        next_state = ST_TURN;
      end
      ST_TURN: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  ram_bus_driver #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bus (
    .clk      (clk),
    .reset    (reset),
    .drive    (mem_cs & mem_we),
    .wr_data  (wr_data),
    .capture  (state == ST_READ),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .mem_data (mem_data)
  );

endmodule
